// File: rtl/gpac_dac_tx_core.sv
// -----------------------------------------------------------------------------
// gpac_dac_tx_core
//
// Streaming DAC transmitter. Sample words are pulled from an upstream
// first-word-fall-through FIFO. Each word is unpacked into two 14-bit samples,
// and the samples are driven to a DAC at a programmable rate. Every new sample
// comes with a one-cycle strobe. The block is configured and started over the
// 8-bit basil IP bus.
//
// Ports:
//   BUS_CLK        single clock for bus, FIFO and DAC side
//   BUS_RST        synchronous active-high reset
//   BUS_ADD        register address (ABUSWIDTH bits)
//   BUS_DATA_IN    write data
//   BUS_RD         read strobe
//   BUS_WR         write strobe
//   BUS_DATA_OUT   registered read data, valid the cycle after BUS_RD
//   DAC_START      external start, honoured when CONF.EN_EXT_START=1
//   FIFO_READ      pop request to upstream FIFO (combinational)
//   FIFO_EMPTY     upstream FIFO empty
//   FIFO_DATA      FWFT data, valid while !FIFO_EMPTY
//   DAC_OUT        DAC sample
//   DAC_STROBE     one-cycle pulse with each new DAC_OUT value
//   BUSY           transfer in progress
//   UNDERRUN_ERROR high while the underrun counter is non-zero
//
// Register map (unlisted addresses read 0):
//   0  W: soft reset          R: VERSION
//   1  W: bit0=1 START        R: {6'b0, BUSY, DONE}
//   2  CONF bit0 EN_EXT_START
//   3  SAMPLE_COUNT[7:0]
//   4  SAMPLE_COUNT[15:8]
//   5  CLKDIV, sample period = CLKDIV+1 cycles
//   6  R: underrun count (saturating)  W: clear
// -----------------------------------------------------------------------------
module gpac_dac_tx_core #(
   parameter int unsigned ABUSWIDTH = 16,
   parameter logic [7:0]  VERSION   = 8'd1
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 DAC_START,
   output logic                 FIFO_READ,
   input  logic                 FIFO_EMPTY,
   input  logic [31:0]          FIFO_DATA,
   output logic [13:0]          DAC_OUT,
   output logic                 DAC_STROBE,
   output logic                 BUSY,
   output logic                 UNDERRUN_ERROR
);

   localparam logic [ABUSWIDTH-1:0] ADDR_RST    = ABUSWIDTH'(8'd0);
   localparam logic [ABUSWIDTH-1:0] ADDR_START  = ABUSWIDTH'(8'd1);
   localparam logic [ABUSWIDTH-1:0] ADDR_CONF   = ABUSWIDTH'(8'd2);
   localparam logic [ABUSWIDTH-1:0] ADDR_CNT_LO = ABUSWIDTH'(8'd3);
   localparam logic [ABUSWIDTH-1:0] ADDR_CNT_HI = ABUSWIDTH'(8'd4);
   localparam logic [ABUSWIDTH-1:0] ADDR_CLKDIV = ABUSWIDTH'(8'd5);
   localparam logic [ABUSWIDTH-1:0] ADDR_UNDER  = ABUSWIDTH'(8'd6);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // ---------------------------------------------------------------- registers
   state_t        r_state;
   logic          r_conf_ext;
   logic [15:0]   r_sample_count;
   logic [7:0]    r_clkdiv;
   logic [7:0]    r_underrun_cnt;
   logic          r_done;
   logic          r_busy;
   logic [15:0]   r_samples_left;
   logic [15:0]   r_words_left;
   logic [7:0]    r_timer;
   logic [27:0]   r_cur_word;     // sample to send next sits in [13:0]
   logic [1:0]    r_cur_cnt;      // samples still unsent in CUR (0..2)
   logic [27:0]   r_nxt_word;
   logic          r_nxt_vld;
   logic [13:0]   r_dac_out;
   logic          r_dac_strobe;
   logic [7:0]    r_bus_data_out;

   // -------------------------------------------------------------------- wires
   logic          w_soft_rst;
   logic          w_rst;
   logic          w_start_wr;
   logic          w_trigger;
   logic          w_under_clr;
   logic          w_fifo_read;
   logic [27:0]   w_fifo_word;
   logic [15:0]   w_words_init;
   logic [7:0]    w_rd_data;
   logic          w_unused_bits;

   state_t        w_state_nxt;
   logic          w_done_nxt;
   logic [15:0]   w_samples_left_nxt;
   logic [15:0]   w_words_left_nxt;
   logic [7:0]    w_timer_nxt;
   logic [27:0]   w_cur_word_nxt;
   logic [1:0]    w_cur_cnt_nxt;
   logic [27:0]   w_nxt_word_nxt;
   logic          w_nxt_vld_nxt;
   logic          w_emit;
   logic [13:0]   w_emit_sample;
   logic          w_underrun;

   // A write to address 0 resets the block on the same edge, so the cycle after
   // the write already shows every register at its default.
   assign w_soft_rst  = BUS_WR && (BUS_ADD == ADDR_RST);
   assign w_rst       = BUS_RST || w_soft_rst;
   assign w_start_wr  = BUS_WR && (BUS_ADD == ADDR_START) && BUS_DATA_IN[0];
   assign w_trigger   = w_start_wr || (r_conf_ext && DAC_START);
   assign w_under_clr = BUS_WR && (BUS_ADD == ADDR_UNDER);

   // Two samples per word: bits 13:0 go out first, then bits 29:16.
   assign w_fifo_word   = {FIFO_DATA[29:16], FIFO_DATA[13:0]};
   assign w_unused_bits = ^{FIFO_DATA[31:30], FIFO_DATA[15:14]};

   // ceil(SAMPLE_COUNT/2) without a 17-bit intermediate.
   assign w_words_init = {1'b0, r_sample_count[15:1]} + {15'd0, r_sample_count[0]};

   // Pop only when the prefetch slot is free. Pops also need a word to be
   // waiting and words to be still owed to this transfer.
   assign w_fifo_read = ((r_state == ST_FILL) || (r_state == ST_RUN)) &&
                        !r_nxt_vld && !FIFO_EMPTY && (r_words_left != 16'd0);

   // Next-state and datapath decisions for the transfer engine.
   always_comb begin
      w_state_nxt        = r_state;
      w_done_nxt         = r_done;
      w_samples_left_nxt = r_samples_left;
      w_words_left_nxt   = r_words_left;
      w_timer_nxt        = r_timer;
      w_cur_word_nxt     = r_cur_word;
      w_cur_cnt_nxt      = r_cur_cnt;
      w_nxt_word_nxt     = r_nxt_word;
      w_nxt_vld_nxt      = r_nxt_vld;
      w_emit             = 1'b0;
      w_emit_sample      = r_dac_out;
      w_underrun         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_trigger) begin
               w_samples_left_nxt = r_sample_count;
               w_words_left_nxt   = w_words_init;
               w_timer_nxt        = 8'd0;
               if (r_sample_count == 16'd0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_done_nxt  = 1'b0;
                  w_state_nxt = ST_FILL;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_FILL: begin
            w_timer_nxt = 8'd0;
            // Leave on the edge that captures the first word so that the first
            // sample slot follows immediately.
            if ((r_cur_cnt != 2'd0) || w_fifo_read) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_FILL;
            end
         end

         ST_RUN: begin
            // A timer above CLKDIV (CLKDIV lowered mid-run) also wraps to 0.
            w_timer_nxt = (r_timer >= r_clkdiv) ? 8'd0 : (r_timer + 8'd1);
            if (r_timer == 8'd0) begin
               if (r_cur_cnt != 2'd0) begin
                  w_emit         = 1'b1;
                  w_emit_sample  = r_cur_word[13:0];
                  w_cur_word_nxt = {14'd0, r_cur_word[27:14]};
                  w_cur_cnt_nxt  = r_cur_cnt - 2'd1;
               end else if (r_nxt_vld) begin
                  w_emit         = 1'b1;
                  w_emit_sample  = r_nxt_word[13:0];
                  w_cur_word_nxt = {14'd0, r_nxt_word[27:14]};
                  w_cur_cnt_nxt  = 2'd1;
                  w_nxt_vld_nxt  = 1'b0;
               end else begin
                  // The sample is not skipped; it is retried at the next slot.
                  w_underrun = 1'b1;
               end

               if (w_emit) begin
                  w_samples_left_nxt = r_samples_left - 16'd1;
               end else begin
                  w_samples_left_nxt = r_samples_left;
               end

               // Last sample out. A leftover upper half of an odd-count word
               // is dropped along with the storage.
               if (w_emit && (r_samples_left == 16'd1)) begin
                  w_state_nxt   = ST_IDLE;
                  w_done_nxt    = 1'b1;
                  w_cur_cnt_nxt = 2'd0;
                  w_nxt_vld_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Place a fetched word after this cycle's slot has been resolved. It goes
      // straight to CUR when CUR would otherwise be empty.
      if (w_fifo_read) begin
         w_words_left_nxt = r_words_left - 16'd1;
         if (w_cur_cnt_nxt == 2'd0) begin
            w_cur_word_nxt = w_fifo_word;
            w_cur_cnt_nxt  = 2'd2;
         end else begin
            w_nxt_word_nxt = w_fifo_word;
            w_nxt_vld_nxt  = 1'b1;
         end
      end else begin
         w_words_left_nxt = w_words_left_nxt;
      end
   end

   // Transfer engine state, sample storage and DAC output registers.
   always_ff @(posedge BUS_CLK) begin
      if (w_rst) begin
         r_state        <= ST_IDLE;
         r_done         <= 1'b0;
         r_busy         <= 1'b0;
         r_samples_left <= 16'd0;
         r_words_left   <= 16'd0;
         r_timer        <= 8'd0;
         r_cur_word     <= 28'd0;
         r_cur_cnt      <= 2'd0;
         r_nxt_word     <= 28'd0;
         r_nxt_vld      <= 1'b0;
         r_dac_out      <= 14'd0;
         r_dac_strobe   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_done         <= w_done_nxt;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_samples_left <= w_samples_left_nxt;
         r_words_left   <= w_words_left_nxt;
         r_timer        <= w_timer_nxt;
         r_cur_word     <= w_cur_word_nxt;
         r_cur_cnt      <= w_cur_cnt_nxt;
         r_nxt_word     <= w_nxt_word_nxt;
         r_nxt_vld      <= w_nxt_vld_nxt;
         r_dac_out      <= w_emit_sample;
         r_dac_strobe   <= w_emit;
      end
   end

   // Configuration registers written over the bus.
   always_ff @(posedge BUS_CLK) begin
      if (w_rst) begin
         r_conf_ext     <= 1'b0;
         r_sample_count <= 16'd0;
         r_clkdiv       <= 8'd0;
      end else if (BUS_WR) begin
         case (BUS_ADD)
            ADDR_CONF:   r_conf_ext           <= BUS_DATA_IN[0];
            ADDR_CNT_LO: r_sample_count[7:0]  <= BUS_DATA_IN;
            ADDR_CNT_HI: r_sample_count[15:8] <= BUS_DATA_IN;
            ADDR_CLKDIV: r_clkdiv             <= BUS_DATA_IN;
            default: begin
               r_conf_ext <= r_conf_ext;
            end
         endcase
      end else begin
         r_conf_ext <= r_conf_ext;
      end
   end

   // Saturating underrun counter; a clear write beats a same-cycle underrun.
   always_ff @(posedge BUS_CLK) begin
      if (w_rst || w_under_clr) begin
         r_underrun_cnt <= 8'd0;
      end else if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end else begin
         r_underrun_cnt <= r_underrun_cnt;
      end
   end

   // Read data selection.
   always_comb begin
      w_rd_data = 8'd0;
      case (BUS_ADD)
         ADDR_RST:    w_rd_data = VERSION;
         ADDR_START:  w_rd_data = {6'd0, r_busy, r_done};
         ADDR_CONF:   w_rd_data = {7'd0, r_conf_ext};
         ADDR_CNT_LO: w_rd_data = r_sample_count[7:0];
         ADDR_CNT_HI: w_rd_data = r_sample_count[15:8];
         ADDR_CLKDIV: w_rd_data = r_clkdiv;
         ADDR_UNDER:  w_rd_data = r_underrun_cnt;
         default:     w_rd_data = 8'd0;
      endcase
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge BUS_CLK) begin
      if (w_rst) begin
         r_bus_data_out <= 8'd0;
      end else if (BUS_RD) begin
         r_bus_data_out <= w_rd_data;
      end else begin
         r_bus_data_out <= r_bus_data_out;
      end
   end

   assign FIFO_READ      = w_fifo_read;
   assign DAC_OUT        = r_dac_out;
   assign DAC_STROBE     = r_dac_strobe;
   assign BUSY           = r_busy;
   assign UNDERRUN_ERROR = (r_underrun_cnt != 8'd0);
   assign BUS_DATA_OUT   = r_bus_data_out;

endmodule

// File: tb/tb_gpac_dac_tx_core.sv
// -----------------------------------------------------------------------------
// tb_gpac_dac_tx_core
//
// Self-checking bench for gpac_dac_tx_core. A queue-style FIFO model feeds the
// DUT. A list of expected samples is built from the words and the sample count
// of each transfer. Every cycle the bench checks DAC_OUT and DAC_STROBE
// against that list. DAC_OUT must hold between strobes and clear on reset.
// Directed checks then cover latency, spacing, read counts and registers.
// -----------------------------------------------------------------------------
module tb_gpac_dac_tx_core;

   logic        BUS_CLK;
   logic        BUS_RST;
   logic [15:0] BUS_ADD;
   logic [7:0]  BUS_DATA_IN;
   logic        BUS_RD;
   logic        BUS_WR;
   logic [7:0]  BUS_DATA_OUT;
   logic        DAC_START;
   logic        FIFO_READ;
   logic        FIFO_EMPTY;
   logic [31:0] FIFO_DATA;
   logic [13:0] DAC_OUT;
   logic        DAC_STROBE;
   logic        BUSY;
   logic        UNDERRUN_ERROR;

   gpac_dac_tx_core #(.ABUSWIDTH(16), .VERSION(8'd1)) dut (
      .BUS_CLK        (BUS_CLK),
      .BUS_RST        (BUS_RST),
      .BUS_ADD        (BUS_ADD),
      .BUS_DATA_IN    (BUS_DATA_IN),
      .BUS_RD         (BUS_RD),
      .BUS_WR         (BUS_WR),
      .BUS_DATA_OUT   (BUS_DATA_OUT),
      .DAC_START      (DAC_START),
      .FIFO_READ      (FIFO_READ),
      .FIFO_EMPTY     (FIFO_EMPTY),
      .FIFO_DATA      (FIFO_DATA),
      .DAC_OUT        (DAC_OUT),
      .DAC_STROBE     (DAC_STROBE),
      .BUSY           (BUSY),
      .UNDERRUN_ERROR (UNDERRUN_ERROR)
   );

   initial BUS_CLK = 1'b0;
   always #5 BUS_CLK = ~BUS_CLK;

   // FIFO model: words pushed by the stimulus, popped when FIFO_READ was high.
   logic [31:0] fifo_mem [0:31];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   assign FIFO_EMPTY = (rd_ptr == wr_ptr);
   assign FIFO_DATA  = fifo_mem[rd_ptr];

   // Expected-sample list and the cycle at which each sample was seen.
   logic [13:0] exp_mem    [0:63];
   int          strobe_cyc [0:63];
   int          exp_rd = 0;
   int          exp_wr = 0;

   logic [13:0] model_out = 14'd0;
   logic        rst_pend  = 1'b0;
   logic        rd_pend   = 1'b0;
   int          cyc       = 0;
   int          n_reads   = 0;
   int          total     = 0;
   int          bad       = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [13:0] sample_of(input logic [31:0] w, input int idx);
      logic [31:0] sh;
      sh = w >> (16 * idx);
      return sh[13:0];
   endfunction

   task automatic push_word(input logic [31:0] w);
      fifo_mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   task automatic expect_sample(input logic [13:0] s);
      exp_mem[exp_wr] = s;
      exp_wr++;
   endtask

   // Expected samples of a transfer: the first n samples of the words in order.
   task automatic expect_words(input logic [31:0] w0, input logic [31:0] w1, input int n);
      for (int i = 0; i < n; i++) begin
         expect_sample(sample_of((i < 2) ? w0 : w1, i % 2));
      end
   endtask

   // One clock: check outputs against the model at the falling edge, then let
   // the rising edge happen and apply its effect on the FIFO model.
   task automatic tick();
      @(negedge BUS_CLK);
      if (rst_pend) begin
         model_out = 14'd0;
         chk("strobe_after_reset", {31'd0, DAC_STROBE}, 32'd0);
      end else if (DAC_STROBE) begin
         chk("strobe_expected", {31'd0, exp_rd < exp_wr}, 32'd1);
         if (exp_rd < exp_wr) begin
            model_out          = exp_mem[exp_rd];
            strobe_cyc[exp_rd] = cyc;
            exp_rd++;
         end
      end
      chk("dac_out", {18'd0, DAC_OUT}, {18'd0, model_out});
      chk("read_while_empty", {31'd0, FIFO_READ & FIFO_EMPTY}, 32'd0);
      rst_pend = BUS_RST || (BUS_WR && (BUS_ADD == 16'd0));
      rd_pend  = FIFO_READ;
      @(posedge BUS_CLK);
      #1;
      cyc++;
      if (rd_pend) begin
         rd_ptr++;
         n_reads++;
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      BUS_ADD     = a;
      BUS_DATA_IN = d;
      BUS_WR      = 1'b1;
      tick();
      BUS_WR      = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      BUS_ADD = a;
      BUS_RD  = 1'b1;
      tick();
      BUS_RD  = 1'b0;
      d       = BUS_DATA_OUT;
   endtask

   logic [7:0] rd;
   int         start_cyc;
   int         base;
   int         reads0;

   initial begin
      for (int i = 0; i < 32; i++) fifo_mem[i] = 32'd0;
      BUS_RST = 1'b1; BUS_ADD = 16'd0; BUS_DATA_IN = 8'd0;
      BUS_RD = 1'b0; BUS_WR = 1'b0; DAC_START = 1'b0;
      @(posedge BUS_CLK); #1;
      @(posedge BUS_CLK); #1;
      tick();
      BUS_RST = 1'b0;
      tick();

      // Reset state
      chk("rst_dac_out", {18'd0, DAC_OUT}, 32'd0);
      chk("rst_strobe", {31'd0, DAC_STROBE}, 32'd0);
      chk("rst_fifo_read", {31'd0, FIFO_READ}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_underrun", {31'd0, UNDERRUN_ERROR}, 32'd0);
      chk("rst_bus_data", {24'd0, BUS_DATA_OUT}, 32'd0);
      bus_read(16'd0, rd); chk("version", {24'd0, rd}, 32'h01);
      bus_read(16'd7, rd); chk("unlisted_addr", {24'd0, rd}, 32'h00);
      bus_read(16'd1, rd); chk("rst_status", {24'd0, rd}, 32'h00);

      // Test 1: 4 samples at P=1, data preloaded
      push_word(32'h0002_0001);
      push_word(32'h0004_0003);
      base = exp_wr;
      expect_words(32'h0002_0001, 32'h0004_0003, 4);
      bus_write(16'd3, 8'd4);
      bus_write(16'd4, 8'd0);
      bus_write(16'd5, 8'd0);
      reads0 = n_reads;
      start_cyc = cyc;
      bus_write(16'd1, 8'd1);
      repeat (8) tick();
      chk("t1_latency", strobe_cyc[base] - start_cyc, 32'd3);
      for (int k = 1; k < 4; k++) chk("t1_gap", strobe_cyc[base + k] - strobe_cyc[base + k - 1], 32'd1);
      chk("t1_all_sent", exp_rd, exp_wr);
      chk("t1_reads", n_reads - reads0, 32'd2);
      chk("t1_busy", {31'd0, BUSY}, 32'd0);
      bus_read(16'd1, rd); chk("t1_status", {24'd0, rd}, 32'h01);
      bus_read(16'd6, rd); chk("t1_underrun", {24'd0, rd}, 32'h00);

      // Test 2: P=4, odd count, third word queued but must not be read
      push_word(32'hC00D_C00C);
      push_word(32'hFFFF_BFFE);
      push_word(32'h0002_0001);
      base = exp_wr;
      expect_sample(14'h000C);
      expect_sample(14'h000D);
      expect_sample(14'h3FFE);
      bus_write(16'd5, 8'd3);
      bus_write(16'd3, 8'd3);
      reads0 = n_reads;
      start_cyc = cyc;
      bus_write(16'd1, 8'd1);
      repeat (16) tick();
      chk("t2_latency", strobe_cyc[base] - start_cyc, 32'd3);
      for (int k = 1; k < 3; k++) chk("t2_gap", strobe_cyc[base + k] - strobe_cyc[base + k - 1], 32'd4);
      chk("t2_all_sent", exp_rd, exp_wr);
      chk("t2_reads", n_reads - reads0, 32'd2);
      chk("t2_busy", {31'd0, BUSY}, 32'd0);

      // Test 3: underrun, second word arrives late
      base = exp_wr;
      expect_words(32'h0002_0001, 32'h0004_0003, 4);
      bus_write(16'd5, 8'd0);
      bus_write(16'd3, 8'd4);
      bus_write(16'd1, 8'd1);
      repeat (10) tick();
      push_word(32'h0004_0003);
      repeat (8) tick();
      chk("t3_all_sent", exp_rd, exp_wr);
      chk("t3_underrun_flag", {31'd0, UNDERRUN_ERROR}, 32'd1);
      bus_read(16'd6, rd); chk("t3_underrun_cnt", {24'd0, rd}, 32'd8);
      bus_write(16'd6, 8'd0);
      chk("t3_flag_cleared", {31'd0, UNDERRUN_ERROR}, 32'd0);
      bus_read(16'd6, rd); chk("t3_cnt_cleared", {24'd0, rd}, 32'd0);

      // Test 4: zero sample count
      push_word(32'h0006_0005);
      bus_write(16'd3, 8'd0);
      reads0 = n_reads;
      bus_write(16'd1, 8'd1);
      chk("t4_busy", {31'd0, BUSY}, 32'd0);
      bus_read(16'd1, rd); chk("t4_done", {24'd0, rd}, 32'h01);
      repeat (3) tick();
      chk("t4_no_reads", n_reads - reads0, 32'd0);

      // Test 5: external start; retriggers while busy are ignored
      push_word(32'h0008_0007);
      push_word(32'h000A_0009);
      push_word(32'h000C_000B);
      base = exp_wr;
      expect_words(32'h0006_0005, 32'h0008_0007, 4);
      bus_write(16'd2, 8'd1);
      bus_write(16'd3, 8'd4);
      reads0 = n_reads;
      start_cyc = cyc;
      DAC_START = 1'b1;
      tick();
      DAC_START = 1'b0;
      tick();
      chk("t5_busy", {31'd0, BUSY}, 32'd1);
      DAC_START = 1'b1;
      tick();
      DAC_START = 1'b0;
      bus_write(16'd1, 8'd1);
      repeat (8) tick();
      chk("t5_latency", strobe_cyc[base] - start_cyc, 32'd3);
      chk("t5_all_sent", exp_rd, exp_wr);
      chk("t5_reads", n_reads - reads0, 32'd2);
      bus_read(16'd1, rd); chk("t5_status", {24'd0, rd}, 32'h01);

      // Test 6: soft reset in the middle of a slow transfer
      bus_write(16'd2, 8'd0);
      bus_write(16'd5, 8'd3);
      expect_sample(14'h0009);
      bus_write(16'd1, 8'd1);
      repeat (4) tick();
      chk("t6_before_reset", exp_rd, exp_wr);
      bus_write(16'd0, 8'd0);
      chk("t6_busy", {31'd0, BUSY}, 32'd0);
      chk("t6_dac_out", {18'd0, DAC_OUT}, 32'd0);
      bus_read(16'd1, rd); chk("t6_status", {24'd0, rd}, 32'h00);
      bus_read(16'd2, rd); chk("t6_conf", {24'd0, rd}, 32'h00);
      bus_read(16'd3, rd); chk("t6_cnt_lo", {24'd0, rd}, 32'h00);
      bus_read(16'd5, rd); chk("t6_clkdiv", {24'd0, rd}, 32'h00);
      bus_read(16'd6, rd); chk("t6_underrun", {24'd0, rd}, 32'h00);
      bus_read(16'd0, rd); chk("t6_version", {24'd0, rd}, 32'h01);
      repeat (10) tick();
      chk("t6_no_more", exp_rd, exp_wr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpac_dac_tx_core.md
Name: gpac_dac_tx_core

Overview:
Streaming DAC transmitter, the output-direction counterpart of the GPAC ADC receive core.
- Pulls 32-bit sample words from an upstream first-word-fall-through FIFO.
- Unpacks two 14-bit samples per word and drives them to a 14-bit DAC at a programmable rate, one strobe per sample.
- Configured and started over the standard 8-bit basil IP bus, normally behind bus_to_ip.

Parameters:
ABUSWIDTH, 16, width of BUS_ADD
VERSION, 8'd1, value returned on read of address 0

Ports:
BUS_CLK  input  1  single clock for bus, FIFO and DAC side
BUS_RST  input  1  synchronous active-high reset
BUS_ADD  input  ABUSWIDTH  register address
BUS_DATA_IN  input  8  write data
BUS_RD  input  1  read strobe
BUS_WR  input  1  write strobe
BUS_DATA_OUT  output  8  read data, registered
DAC_START  input  1  external start, used when EN_EXT_START=1
FIFO_READ  output  1  pop request to upstream FIFO
FIFO_EMPTY  input  1  upstream FIFO empty
FIFO_DATA  input  32  FWFT data, valid while !FIFO_EMPTY
DAC_OUT  output  14  DAC sample
DAC_STROBE  output  1  one-cycle pulse, coincident with each new DAC_OUT value
BUSY  output  1  transfer in progress
UNDERRUN_ERROR  output  1  high while UNDERRUN_CNT != 0

Behaviour:
- Reset:
  - BUS_RST=1, or a write to address 0, resets all registers to their defaults. A soft reset takes effect the cycle after the write.
  - Reset values: DAC_OUT=0, DAC_STROBE=0, FIFO_READ=0, BUSY=0, UNDERRUN_ERROR=0, DONE=0, BUS_DATA_OUT=0.
  - Reset aborts any transfer. Fetched but unsent words are discarded.
- Register map (unlisted addresses read 0):
  - 0: W = soft reset; R = VERSION.
  - 1: W bit0=1 = START; R = {6'b0, BUSY, DONE}.
  - 2: CONF. bit0 EN_EXT_START. Default 0.
  - 3/4: SAMPLE_COUNT[7:0] / [15:8]. Default 0.
  - 5: CLKDIV. Default 0. Sample period P = CLKDIV+1 cycles.
  - 6: R = UNDERRUN_CNT (8-bit, saturates at 255); W = clear.
- Read latency: BUS_DATA_OUT is valid the cycle after BUS_RD.
- Word format: FIFO_DATA[13:0] is sample 0 (sent first); FIFO_DATA[29:16] is sample 1. Bits 31:30 and 15:14 are ignored.
- Storage: two word registers, CUR (with 0–2 remaining samples) and NXT.
- FIFO_READ is combinational and asserted only when all of the following hold:
  - state is FILL or RUN;
  - NXT is empty;
  - !FIFO_EMPTY;
  - WORDS_LEFT != 0, where WORDS_LEFT = ceil(SAMPLE_COUNT/2) is loaded at start.
  - The word is captured on that edge.
  - FIFO_READ is never asserted while FIFO_EMPTY=1.
- State machine:
  - IDLE: accepts a start trigger.
    - Trigger is a START write, or DAC_START=1 when EN_EXT_START=1.
    - On trigger: clear DONE, latch SAMPLE_COUNT into SAMPLES_LEFT, compute WORDS_LEFT.
    - If SAMPLE_COUNT=0: DONE=1 next cycle, stay IDLE, no FIFO reads.
    - Otherwise go to FILL with BUSY=1.
  - FILL: fetch until CUR holds a word (NXT prefetch allowed), then go to RUN with the sample timer at 0. No underruns are counted in FILL.
  - RUN: the timer counts 0..CLKDIV and a sample slot occurs when timer=0.
    - At a slot with a sample available (CUR, else NXT moved into CUR): DAC_OUT is updated, DAC_STROBE=1, SAMPLES_LEFT decrements.
    - At a slot with no sample available: no strobe, DAC_OUT holds, UNDERRUN_CNT+1 (saturating). The sample is not skipped; the next attempt is at the next slot.
    - When SAMPLES_LEFT reaches 0: go to IDLE next cycle, BUSY=0, DONE=1.
    - For odd SAMPLE_COUNT, the upper sample of the last word is discarded.
- Latency: with data already in the FIFO and P=1, the first DAC_STROBE occurs 3 cycles after the START write cycle. Subsequent strobes are every P cycles.
- Throughput: sustained at P=1 with no underruns while the FIFO stays non-empty.
- DAC_OUT holds the last sample after completion, until the next strobe or reset.
- START or DAC_START while BUSY is ignored.
- A write to register 6 in the same cycle as an underrun clears the counter; the clear wins.

Test Plan:
1. FIFO preloaded with 0x0002_0001, 0x0004_0003; SAMPLE_COUNT=4, CLKDIV=0; START → DAC_OUT 1,2,3,4 on 4 consecutive strobes; first strobe 3 cycles after the START write; exactly 2 FIFO_READ pulses; DONE=1, BUSY=0; UNDERRUN_CNT=0.
2. CLKDIV=3, SAMPLE_COUNT=3, 2 words queued → strobes 4 cycles apart; samples 0,1,2 sent; the fourth sample is dropped; exactly 2 reads, no third.
3. SAMPLE_COUNT=4, CLKDIV=0; only 1 word present at start, second word pushed 10 cycles later → UNDERRUN_CNT>0; UNDERRUN_ERROR=1; DAC_OUT holds 2; samples 3,4 are still sent in order. Then write address 6 → count=0.
4. SAMPLE_COUNT=0 with START → DONE=1 the next cycle; FIFO_READ never asserted.
5. EN_EXT_START=1, DAC_START pulse → transfer runs. A second DAC_START and a START write while BUSY are both ignored.
6. Soft reset (write address 0) mid-RUN → next cycle BUSY=0, DAC_OUT=0, DONE=0, all registers at defaults; reading address 0 returns 0x01.
